// File: rtl/packet_sum_pkg.sv
// Shared widths and types for the packet_sum streaming byte reducer.
package packet_sum_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int SUM_WIDTH  = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SUM_WIDTH-1:0]  sum_t;

endpackage

// File: rtl/packet_sum_out_reg.sv
// Single-entry valid/ready output register.
// Upstream may load a new word in the same cycle the held word is taken,
// so back-to-back words flow at one per cycle without a bubble.
module packet_sum_out_reg
  import packet_sum_pkg::*;
#(
  parameter int WIDTH = packet_sum_pkg::SUM_WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Room for a new word when empty or when the held word leaves this cycle.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next state: load on an accepted word, otherwise drop valid once taken.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output word and its valid flag; reset empties the register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/packet_sum.sv
// Streaming reducer: sums the unsigned bytes of each packet (delimited by
// input_last) and emits one wrap-around sum per packet through a
// single-entry output register.
module packet_sum
  import packet_sum_pkg::*;
#(
  parameter int DATA_WIDTH = packet_sum_pkg::DATA_WIDTH,
  parameter int SUM_WIDTH  = packet_sum_pkg::SUM_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_last,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [SUM_WIDTH-1:0]  output_data
);

  // Unsigned add of a zero-extended byte; overflow wraps silently.
  function automatic logic [SUM_WIDTH-1:0] add_wrap(
    input logic [SUM_WIDTH-1:0]  acc,
    input logic [DATA_WIDTH-1:0] beat
  );
    return acc + SUM_WIDTH'(beat);
  endfunction

  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_WIDTH-1:0] sum_next;
  logic                 beat_fire;

  assign sum_next  = add_wrap(acc_q, input_data);
  assign beat_fire = input_valid && input_ready;

  // Accumulate accepted beats; the last beat hands the total off and restarts at zero.
  always_comb begin
    acc_d = acc_q;
    if (beat_fire) begin
      acc_d = input_last ? '0 : sum_next;
    end
  end

  // Running partial sum of the packet in flight; reset discards it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Input readiness comes straight from the output register, so a stalled
  // consumer also freezes the accumulator.
  packet_sum_out_reg #(
    .WIDTH (SUM_WIDTH)
  ) u_out_reg (
    .clock_i     (clock),
    .reset_i     (reset),
    .in_valid_i  (input_valid && input_last),
    .in_ready_o  (input_ready),
    .in_data_i   (sum_next),
    .out_valid_o (output_valid),
    .out_ready_i (output_ready),
    .out_data_o  (output_data)
  );

endmodule

// File: tb/tb_packet_sum.sv
// Bench for packet_sum: directed cycle tables, overflow and reset sequences,
// and a randomized stream checked against a queue-based packet-sum model.
module tb_packet_sum;
  import packet_sum_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  logic  input_valid;
  logic  input_ready;
  data_t input_data;
  logic  input_last;
  logic  output_valid;
  logic  output_ready;
  sum_t  output_data;

  packet_sum dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: expected packet sums awaiting delivery, plus the
  // plain integer total of the packet currently being received.
  sum_t        exp_q[$];
  int unsigned psum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at the falling edge, before the rising edge that commits transfers.
  task automatic model_step();
    chk("in_ready_rule", 32'(input_ready), 32'(!output_valid || output_ready));
    if (output_valid) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(1), 32'(0));
      else chk("out_data_model", 32'(output_data), 32'(exp_q[0]));
    end else begin
      chk("pending_words", 32'(exp_q.size()), 32'(0));
    end
    if (output_valid && output_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (input_valid && input_ready) begin
      psum += input_data;
      if (input_last) begin
        exp_q.push_back(sum_t'(psum % 65536));
        psum = 0;
      end
    end
  endtask

  // One clock cycle: drive, sample ready at the falling edge, settle after the rising edge.
  task automatic cycle(input logic v, input data_t d, input logic l, input logic r, output logic rdy);
    input_valid  = v;
    input_data   = d;
    input_last   = l;
    output_ready = r;
    @(negedge clock);
    rdy = input_ready;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    input_valid = 1'b0;
    input_last  = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    psum = 0;
    #2;
    chk("rst_out_valid", 32'(output_valid), 32'(0));
    chk("rst_out_data", 32'(output_data), 32'(0));
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(input_ready), 32'(1));
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic  v;
    data_t d;
    logic  l;
    logic  r;
    logic  exp_rdy;
    logic  exp_ov;
    sum_t  exp_od;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic  rdy;
    logic  presenting;
    data_t cnt;
    int    remaining;

    input_valid  = 1'b0;
    input_data   = '0;
    input_last   = 1'b0;
    output_ready = 1'b0;

    // {valid, data, last, out_ready, expected ready, expected valid, expected data}
    // Packet 00,01,02: sum one cycle after last, valid for exactly one cycle.
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    // Back-to-back single-beat packets.
    tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005});
    tbl.push_back('{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0007});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    // FF,FF with the consumer stalled, then release.
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'h01FE});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FE});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FE});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0034});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});

    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, rdy);
      chk($sformatf("tbl%0d_in_ready", i), 32'(rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(output_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) chk($sformatf("tbl%0d_out_data", i), 32'(output_data), 32'(tbl[i].exp_od));
    end

    // Overflow: 258 beats of FF (last on the final one) wraps to 0x00FE.
    for (int i = 0; i < 257; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b1, rdy);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1, rdy);
    chk("ovf_valid", 32'(output_valid), 32'(1));
    chk("ovf_data", 32'(output_data), 32'(16'h00FE));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, rdy);

    // Reset while a stalled word is held clears it.
    cycle(1'b1, 8'h40, 1'b1, 1'b0, rdy);
    chk("held_before_reset", 32'(output_valid), 32'(1));
    do_reset();

    // Reset mid-packet discards the partial sum.
    cycle(1'b1, 8'h10, 1'b0, 1'b1, rdy);
    cycle(1'b1, 8'h20, 1'b0, 1'b1, rdy);
    do_reset();
    cycle(1'b1, 8'h01, 1'b0, 1'b1, rdy);
    cycle(1'b1, 8'h02, 1'b1, 1'b1, rdy);
    chk("post_reset_valid", 32'(output_valid), 32'(1));
    chk("post_reset_data", 32'(output_data), 32'(16'h0003));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, rdy);
    chk("post_reset_pulse", 32'(output_valid), 32'(0));

    // Random: counter bytes, packet lengths 1..10, gapped input, ~80% consumer ready.
    cnt        = 8'h00;
    remaining  = $urandom_range(1, 10);
    presenting = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!presenting) presenting = ($urandom_range(0, 9) != 0);
      cycle(presenting, cnt, remaining == 1, $urandom_range(0, 99) < 80, rdy);
      if (presenting && rdy) begin
        cnt++;
        remaining--;
        if (remaining == 0) remaining = $urandom_range(1, 10);
        presenting = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, 1'b1, rdy);
    chk("drain_all_delivered", 32'(exp_q.size()), 32'(0));
    chk("drain_valid_low", 32'(output_valid), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
